// File: rtl/board_writer_if.sv
// +-----------------------------------------------------------------------+
// | Module : board_writer_if                                              |
// | Desc   : Move/load request bus and board status outputs of the board  |
// |          writer, bundled for use as a single port.                    |
// | Rev    : 1.0  initial release                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

interface board_writer_if;
   logic         move_valid;
   logic         move_ready;
   logic [5:0]   from_pos;
   logic [5:0]   to_pos;
   logic [2:0]   promo_piece;
   logic         load_valid;
   logic [255:0] load_board;
   logic [255:0] bigBoard;
   logic         turn;
   logic         move_done;
   logic         move_error;
   logic [3:0]   captured_piece;

   // Requester side: issues moves and board loads, observes the board.
   modport master (
      output move_valid, from_pos, to_pos, promo_piece, load_valid, load_board,
      input  move_ready, bigBoard, turn, move_done, move_error, captured_piece
   );

   // Board writer side.
   modport slave (
      input  move_valid, from_pos, to_pos, promo_piece, load_valid, load_board,
      output move_ready, bigBoard, turn, move_done, move_error, captured_piece
   );
endinterface

`default_nettype wire

// File: rtl/board_writer.sv
// +-----------------------------------------------------------------------+
// | Module : board_writer                                                 |
// | Desc   : Holds the chess board image and applies one move at a time: |
// |          read source/destination, reject obviously bad moves, write  |
// |          the piece (with pawn promotion), move the rook on castling, |
// |          then pulse move_done and hand the turn over.                |
// | Rev    : 1.0  initial release                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

module board_writer #(
   parameter bit INIT_TURN = 1'b0
) (
   input  logic          clk,
   input  logic          rst,
   board_writer_if.slave bus
);

   typedef enum logic [2:0] {IDLE, READ, WRITE, ROOK, DONE} state_t;

   // Standard start position, square i at nibble i (row 0 = black back rank).
   localparam logic [255:0] c_start_board =
      256'h42365324_11111111_00000000_00000000_00000000_00000000_99999999_CABEDBAC;

   state_t       state_q, state_d;
   logic [255:0] board_q, board_d;
   logic         turn_q, turn_d;
   logic [5:0]   from_q, from_d;
   logic [5:0]   to_q, to_d;
   logic [2:0]   promo_q, promo_d;
   logic [3:0]   src_q, src_d;
   logic [3:0]   dst_q, dst_d;
   logic         done_q, done_d;
   logic         error_q, error_d;
   logic [3:0]   cap_q, cap_d;

   logic         w_reject;
   logic         w_castle;
   logic         w_promote;
   logic [2:0]   w_promo_type;
   logic [3:0]   w_placed;
   logic [5:0]   w_rook_from;
   logic [5:0]   w_rook_to;

   // Only sanity checks are made here; geometric legality belongs to the checker.
   assign w_reject = (src_q[2:0] == 3'd0) || (src_q[2:0] == 3'd7) ||
                     (src_q[3] != turn_q) || (from_q == to_q) ||
                     ((dst_q[2:0] != 3'd0) && (dst_q[3] == src_q[3]));

   // King leaving the e-file towards c/g on its own rank triggers the rook hop.
   assign w_castle = (src_q[2:0] == 3'd6) && (from_q[2:0] == 3'd4) &&
                     (to_q[5:3] == from_q[5:3]) &&
                     ((to_q[2:0] == 3'd6) || (to_q[2:0] == 3'd2));

   assign w_promote = (src_q[2:0] == 3'd1) &&
                      ((!src_q[3] && (to_q[5:3] == 3'd0)) ||
                       ( src_q[3] && (to_q[5:3] == 3'd7)));

   assign w_promo_type = ((promo_q >= 3'd2) && (promo_q <= 3'd5)) ? promo_q : 3'd5;
   assign w_placed     = w_promote ? {src_q[3], w_promo_type} : src_q;
   assign w_rook_from  = {from_q[5:3], (to_q[2:0] == 3'd6) ? 3'd7 : 3'd0};
   assign w_rook_to    = {from_q[5:3], (to_q[2:0] == 3'd6) ? 3'd5 : 3'd3};

   assign bus.move_ready     = (state_q == IDLE) && !bus.load_valid;
   assign bus.bigBoard       = board_q;
   assign bus.turn           = turn_q;
   assign bus.move_done      = done_q;
   assign bus.move_error     = error_q;
   assign bus.captured_piece = cap_q;

   // Next-state and next-board computation for every stage of a move.
   always_comb begin
      state_d = state_q;
      board_d = board_q;
      turn_d  = turn_q;
      from_d  = from_q;
      to_d    = to_q;
      promo_d = promo_q;
      src_d   = src_q;
      dst_d   = dst_q;
      done_d  = 1'b0;
      error_d = 1'b0;
      cap_d   = 4'h0;
      case (state_q)
         IDLE: begin
            if (bus.load_valid) begin
               board_d = bus.load_board;
            end else if (bus.move_valid) begin
               from_d  = bus.from_pos;
               to_d    = bus.to_pos;
               promo_d = bus.promo_piece;
               state_d = READ;
            end
         end
         READ: begin
            src_d   = board_q[{from_q, 2'b00} +: 4];
            dst_d   = board_q[{to_q, 2'b00} +: 4];
            state_d = WRITE;
         end
         WRITE: begin
            if (w_reject) begin
               done_d  = 1'b1;
               error_d = 1'b1;
               state_d = DONE;
            end else begin
               board_d[{from_q, 2'b00} +: 4] = 4'h0;
               board_d[{to_q, 2'b00} +: 4]   = w_placed;
               if (w_castle) begin
                  state_d = ROOK;
               end else begin
                  done_d  = 1'b1;
                  cap_d   = dst_q;
                  state_d = DONE;
               end
            end
         end
         ROOK: begin
            board_d[{w_rook_to, 2'b00} +: 4]   = board_q[{w_rook_from, 2'b00} +: 4];
            board_d[{w_rook_from, 2'b00} +: 4] = 4'h0;
            done_d  = 1'b1;
            cap_d   = dst_q;
            state_d = DONE;
         end
         DONE: begin
            if (!error_q) turn_d = ~turn_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State register; reset restores the start position and drops any move in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         board_q <= c_start_board;
         turn_q  <= INIT_TURN;
         from_q  <= 6'd0;
         to_q    <= 6'd0;
         promo_q <= 3'd0;
         src_q   <= 4'h0;
         dst_q   <= 4'h0;
         done_q  <= 1'b0;
         error_q <= 1'b0;
         cap_q   <= 4'h0;
      end else begin
         state_q <= state_d;
         board_q <= board_d;
         turn_q  <= turn_d;
         from_q  <= from_d;
         to_q    <= to_d;
         promo_q <= promo_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         done_q  <= done_d;
         error_q <= error_d;
         cap_q   <= cap_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_board_writer.sv
// +-----------------------------------------------------------------------+
// | Module : tb_board_writer                                              |
// | Desc   : Bench for board_writer: square-array reference model,        |
// |          per-cycle output compare, directed and random moves/loads.   |
// | Rev    : 1.0  initial release                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_board_writer;
   localparam bit INIT = 1'b0;
   localparam logic [255:0] START_LIT =
      256'h42365324_11111111_00000000_00000000_00000000_00000000_99999999_CABEDBAC;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   board_writer_if bus();
   board_writer #(.INIT_TURN(INIT)) dut (.clk(clk), .rst(rst), .bus(bus));

   int n_vec = 0;
   int n_bad = 0;

   // Reference model: one nibble per square plus side to move.
   logic [3:0] m_sq [64];
   logic       m_turn;

   logic         exp_ready, exp_done, exp_err, exp_turn;
   logic [3:0]   exp_cap;
   logic [255:0] exp_board;
   bit           chk_en = 1'b0;

   logic [3:0] last_cap;
   logic       last_err;
   int         last_lat;

   function automatic logic [255:0] pack_model();
      logic [255:0] b;
      for (int i = 0; i < 64; i++) b[4*i +: 4] = m_sq[i];
      return b;
   endfunction

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] want);
      n_vec++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, want);
      end
   endtask

   // Every cycle outputs are compared against the model's expectation.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("move_ready", 256'(bus.move_ready), 256'(exp_ready));
         chk("move_done", 256'(bus.move_done), 256'(exp_done));
         chk("move_error", 256'(bus.move_error), 256'(exp_err));
         chk("captured", 256'(bus.captured_piece), 256'(exp_cap));
         chk("turn", 256'(bus.turn), 256'(exp_turn));
         chk("bigBoard", bus.bigBoard, exp_board);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle_inputs();
      bus.move_valid = 1'b0;
      bus.load_valid = 1'b0;
   endtask

   task automatic set_busy_inputs();
      bus.move_valid  = 1'($urandom_range(0, 1));
      bus.from_pos    = 6'($urandom_range(0, 63));
      bus.to_pos      = 6'($urandom_range(0, 63));
      bus.promo_piece = 3'($urandom_range(0, 7));
      bus.load_valid  = 1'b0;
   endtask

   task automatic exp_from_model(input logic rdy);
      exp_ready = rdy;
      exp_done  = 1'b0;
      exp_err   = 1'b0;
      exp_cap   = 4'h0;
      exp_board = pack_model();
      exp_turn  = m_turn;
   endtask

   task automatic model_reset();
      logic [31:0] back;
      back = 32'h42365324;
      for (int i = 0; i < 64; i++) m_sq[i] = 4'h0;
      for (int c = 0; c < 8; c++) begin
         m_sq[c]      = back[4*c +: 4] | 4'h8;
         m_sq[8 + c]  = 4'h9;
         m_sq[48 + c] = 4'h1;
         m_sq[56 + c] = back[4*c +: 4];
      end
      m_turn = INIT;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      set_idle_inputs();
      tick();
      model_reset();
      exp_from_model(1'b1);
      chk_en = 1'b1;
      rst = 1'b0;
   endtask

   task automatic note_done(input int k);
      if (bus.move_done === 1'b1 && last_lat == 0) last_lat = k + 1;
   endtask

   task automatic do_move(input int f, input int t, input logic [2:0] p);
      logic [3:0] src, dst, piece;
      bit rej, castle;
      int rf, rt;
      bus.move_valid  = 1'b1;
      bus.load_valid  = 1'b0;
      bus.from_pos    = 6'(f);
      bus.to_pos      = 6'(t);
      bus.promo_piece = p;
      exp_ready = 1'b1;
      last_lat  = 0;
      tick();                       // accept edge T
      set_busy_inputs();
      exp_ready = 1'b0;
      tick(); note_done(1);
      set_busy_inputs();
      src = m_sq[f];
      dst = m_sq[t];
      rej = (src[2:0] == 3'd0) || (src[2:0] == 3'd7) || (src[3] != m_turn) ||
            (f == t) || ((dst[2:0] != 3'd0) && (dst[3] == src[3]));
      castle = !rej && (src[2:0] == 3'd6) && (f % 8 == 4) && (f / 8 == t / 8) &&
               ((t % 8 == 6) || (t % 8 == 2));
      if (!rej) begin
         piece = src;
         if (src[2:0] == 3'd1 && ((!src[3] && t / 8 == 0) || (src[3] && t / 8 == 7)))
            piece = {src[3], ((p >= 3'd2 && p <= 3'd5) ? p : 3'd5)};
         m_sq[f] = 4'h0;
         m_sq[t] = piece;
      end
      tick(); note_done(2);
      if (castle) begin
         exp_board = pack_model();
         set_busy_inputs();
         tick(); note_done(3);
         rf = (t % 8 == 6) ? (f - 4 + 7) : (f - 4);
         rt = (t % 8 == 6) ? (f - 4 + 5) : (f - 4 + 3);
         m_sq[rt] = m_sq[rf];
         m_sq[rf] = 4'h0;
      end
      exp_board = pack_model();
      exp_done  = 1'b1;
      exp_err   = rej;
      exp_cap   = rej ? 4'h0 : dst;
      exp_turn  = m_turn;
      last_cap  = bus.captured_piece;
      last_err  = bus.move_error;
      set_busy_inputs();
      tick();
      if (!rej) m_turn = ~m_turn;
      set_idle_inputs();
      exp_from_model(1'b1);
   endtask

   task automatic do_move_reset(input int f, input int t);
      bus.move_valid = 1'b1;
      bus.load_valid = 1'b0;
      bus.from_pos   = 6'(f);
      bus.to_pos     = 6'(t);
      exp_ready = 1'b1;
      tick();
      set_busy_inputs();
      exp_ready = 1'b0;
      tick();
      set_busy_inputs();
      rst = 1'b1;
      tick();                       // reset lands on edge T+2
      model_reset();
      rst = 1'b0;
      set_idle_inputs();
      exp_from_model(1'b1);
   endtask

   task automatic do_load(input logic [255:0] img, input logic mv);
      bus.load_valid = 1'b1;
      bus.load_board = img;
      bus.move_valid = mv;
      bus.from_pos   = 6'd52;
      bus.to_pos     = 6'd36;
      exp_ready = 1'b0;
      tick();
      for (int i = 0; i < 64; i++) m_sq[i] = img[4*i +: 4];
      set_idle_inputs();
      exp_from_model(1'b1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [255:0] img;
      int f, t, c, r;
      bus.move_valid = 1'b0; bus.load_valid = 1'b0; bus.load_board = '0;
      bus.from_pos = 6'd0; bus.to_pos = 6'd0; bus.promo_piece = 3'd0;

      // Reset state
      do_reset();
      chk("reset_board_lit", bus.bigBoard, START_LIT);
      chk("reset_turn_lit", 256'(bus.turn), 256'(1'b0));

      // Simple pawn push
      do_move(52, 36, 3'd0);
      chk("e4_sq36", 256'(bus.bigBoard[36*4 +: 4]), 256'(4'h1));
      chk("e4_sq52", 256'(bus.bigBoard[52*4 +: 4]), 256'(4'h0));
      chk("e4_cap", 256'(last_cap), 256'(4'h0));
      chk("e4_err", 256'(last_err), 256'(1'b0));
      chk("e4_turn", 256'(bus.turn), 256'(1'b1));
      chk("e4_latency", 256'(last_lat), 256'(3));

      // Empty source rejected
      do_reset();
      do_move(20, 28, 3'd0);
      chk("empty_err", 256'(last_err), 256'(1'b1));
      chk("empty_board", bus.bigBoard, START_LIT);
      chk("empty_turn", 256'(bus.turn), 256'(1'b0));

      // Kingside castle
      do_reset();
      img = '0; img[60*4 +: 4] = 4'h6; img[63*4 +: 4] = 4'h4;
      do_load(img, 1'b0);
      do_move(60, 62, 3'd0);
      chk("castle_latency", 256'(last_lat), 256'(4));
      chk("castle_sq62", 256'(bus.bigBoard[62*4 +: 4]), 256'(4'h6));
      chk("castle_sq61", 256'(bus.bigBoard[61*4 +: 4]), 256'(4'h4));
      chk("castle_sq60", 256'(bus.bigBoard[60*4 +: 4]), 256'(4'h0));
      chk("castle_sq63", 256'(bus.bigBoard[63*4 +: 4]), 256'(4'h0));

      // Promotion with capture, explicit and defaulted type
      do_reset();
      img = '0; img[8*4 +: 4] = 4'h1; img[0*4 +: 4] = 4'hC;
      do_load(img, 1'b0);
      do_move(8, 0, 3'd2);
      chk("promo_knight", 256'(bus.bigBoard[0 +: 4]), 256'(4'h2));
      chk("promo_cap", 256'(last_cap), 256'(4'hC));
      do_reset();
      do_load(img, 1'b0);
      do_move(8, 0, 3'd7);
      chk("promo_queen", 256'(bus.bigBoard[0 +: 4]), 256'(4'h5));

      // Reset in the middle of a move
      do_reset();
      do_move_reset(52, 36);
      tick(); tick();
      chk("abort_board", bus.bigBoard, START_LIT);
      chk("abort_turn", 256'(bus.turn), 256'(1'b0));

      // Load wins over a simultaneous move request
      for (int i = 0; i < 8; i++) img[32*i +: 32] = $urandom;
      do_load(img, 1'b1);
      tick(); tick(); tick();
      chk("load_prio_board", bus.bigBoard, img);

      // Random traffic
      do_reset();
      for (int n = 0; n < 150; n++) begin
         r = $urandom_range(0, 19);
         if (r == 0) begin
            for (int i = 0; i < 64; i++)
               img[4*i +: 4] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            if ($urandom_range(0, 1) == 1) begin
               img[4*4 +: 4] = 4'hE; img[0 +: 4] = 4'hC; img[7*4 +: 4] = 4'hC;
               img[60*4 +: 4] = 4'h6; img[56*4 +: 4] = 4'h4; img[63*4 +: 4] = 4'h4;
            end
            do_load(img, 1'($urandom_range(0, 1)));
         end else if (r == 1) begin
            do_reset();
         end else if (r == 2) begin
            do_move_reset($urandom_range(0, 63), $urandom_range(0, 63));
         end else begin
            f = $urandom_range(0, 63);
            if (r < 6) begin
               f = m_turn ? 4 : 60;
               t = ($urandom_range(0, 1) == 1) ? f + 2 : f - 2;
            end else begin
               if ($urandom_range(0, 3) != 0) begin
                  for (int k = 0; k < 64; k++) begin
                     c = $urandom_range(0, 63);
                     if (m_sq[c][2:0] != 3'd0 && m_sq[c][2:0] != 3'd7 && m_sq[c][3] == m_turn) begin
                        f = c;
                        break;
                     end
                  end
               end
               t = $urandom_range(0, 63);
            end
            do_move(f, t, 3'($urandom_range(0, 7)));
         end
         for (int k = $urandom_range(0, 2); k > 0; k--) tick();
      end

      tick();
      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/board_writer.md
BOARD_WRITER -- requirements
Module: board_writer

Interface
REQ-001 SHALL have parameter INIT_TURN, default 0, meaning side to move after reset (0 white, 1 black).
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-004 SHALL have port move_valid  input  1  move request present.
REQ-005 SHALL have port move_ready  output  1  block accepts a move this cycle.
REQ-006 SHALL have port from_pos  input  6  source square, index = row*8+col, row 0 at top.
REQ-007 SHALL have port to_pos  input  6  destination square.
REQ-008 SHALL have port promo_piece  input  3  promotion type.
REQ-009 SHALL have port load_valid  input  1  overwrite whole board.
REQ-010 SHALL have port load_board  input  256  board image for load.
REQ-011 SHALL have port bigBoard  output  256  registered board; square i at bits [4i+3:4i].
REQ-012 SHALL have port turn  output  1  side to move.
REQ-013 SHALL have port move_done  output  1  one-cycle completion pulse.
REQ-014 SHALL have port move_error  output  1  move was rejected; valid with move_done.
REQ-015 SHALL have port captured_piece  output  4  prior destination contents; valid with move_done.

Function
REQ-016 Piece code SHALL be: bit3 colour (0 white, 1 black); bits2:0 type: 0 empty, 1 pawn, 2 knight, 3 bishop, 4 rook, 5 queen, 6 king, 7 invalid.
REQ-017 FSM states SHALL be IDLE, READ, WRITE, ROOK, DONE.
REQ-018 move_ready SHALL be 1 only in IDLE with load_valid=0.
REQ-019 In IDLE, load_valid=1 SHALL copy load_board into bigBoard next edge, leave turn unchanged, not pulse move_done; load has priority over move_valid.
REQ-020 Move accepted on edge T (IDLE, move_valid&move_ready) SHALL latch from_pos, to_pos, promo_piece; inputs are don't-care afterwards.
REQ-021 READ (T+1) SHALL register src=square[from], dst=square[to].
REQ-022 Move SHALL be rejected when src type is 0 or 7, src colour != turn, from==to, or dst non-empty with colour == src colour.
REQ-023 Rejected move: bigBoard and turn unchanged; DONE with move_error=1, captured_piece=0.
REQ-024 Accepted move, WRITE: square[from]<=0, square[to]<=src, or promoted code if pawn reaches row 0 (white) or row 7 (black).
REQ-025 Promotion type SHALL be promo_piece when 2..5, else queen (5); colour kept.
REQ-026 Castling SHALL apply when src is king at col 4 moving within same row to col 6 or col 2: ROOK state moves rook col7->col5 or col0->col3; rook-square contents are not checked.
REQ-027 Non-castling moves SHALL skip ROOK (WRITE->DONE).
REQ-028 In DONE, move_done=1 one cycle, move_error per REQ-022, captured_piece=dst; turn toggles on accepted move only; next state IDLE.
REQ-029 Updated bigBoard SHALL be visible in the move_done cycle: T+3 normal, T+4 castling.
REQ-030 Move legality (geometry, check) SHALL NOT be evaluated; that is the scanner/checker's job.
REQ-031 move_done, move_error, captured_piece SHALL be 0 outside DONE.

Reset
REQ-032 rst=1 SHALL force IDLE, turn=INIT_TURN, move_done=0, move_error=0, captured_piece=0, and load standard start position: row0 black R N B Q K B N R (C,A,B,D,E,B,A,C hex), row1 black pawns (9), rows2-5 empty, row6 white pawns (1), row7 white R N B Q K B N R (4,2,3,5,6,3,2,4).
REQ-033 rst asserted mid-move SHALL abort it with no partial board write and no move_done pulse.
REQ-034 rst SHALL take priority over load_valid and move_valid.

Verification
REQ-035 Reset, move 52->36 -> move_done at T+3, sq36=1, sq52=0, captured=0, error=0, turn=1.
REQ-036 After reset, move 20->28 (empty source) -> move_done, error=1, bigBoard unchanged, turn=0.
REQ-037 Load sq60=6, sq63=4, rest 0, turn 0; move 60->62 -> move_done at T+4, sq62=6, sq61=4, sq60=0, sq63=0.
REQ-038 Load white pawn sq8=1, black rook sq0=C; move 8->0 promo=2 -> sq0=2, captured=C; repeat with promo=7 -> sq0=5.
REQ-039 Start move 52->36, assert rst at T+2 -> no move_done, bigBoard equals start position, turn=0.
REQ-040 load_valid and move_valid both high in IDLE -> board = load_board, move_ready=0, no move_done.
